// File: rtl/mem_wb_writeback_if.sv
// MEM/WB writeback bus: memory-stage results in, register-file write port and
// decode-stage bypassed read data out.
interface mem_wb_writeback_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
);
    logic                   MEM_WB_regwrite;
    logic                   MEM_WB_memtoreg;
    logic [DATA_WIDTH-1:0]  read_data;
    logic [DATA_WIDTH-1:0]  mem_alu_result;
    logic [4:0]             mem_write_reg;
    logic                   wb_hold;
    logic                   wb_flush;
    logic [4:0]             id_rs;
    logic [4:0]             id_rt;
    logic [DATA_WIDTH-1:0]  id_rdata1_in;
    logic [DATA_WIDTH-1:0]  id_rdata2_in;

    logic [4:0]             MEM_WB_rd;
    logic                   wb_regwrite;
    logic [DATA_WIDTH-1:0]  WB_mux5_writedata;
    logic [DATA_WIDTH-1:0]  id_rdata1_out;
    logic [DATA_WIDTH-1:0]  id_rdata2_out;
    logic [COUNT_WIDTH-1:0] retire_count;

    // Master is the surrounding pipeline (memory and decode stages).
    modport master (
        output MEM_WB_regwrite, MEM_WB_memtoreg, read_data, mem_alu_result,
               mem_write_reg, wb_hold, wb_flush, id_rs, id_rt,
               id_rdata1_in, id_rdata2_in,
        input  MEM_WB_rd, wb_regwrite, WB_mux5_writedata,
               id_rdata1_out, id_rdata2_out, retire_count
    );

    modport slave (
        input  MEM_WB_regwrite, MEM_WB_memtoreg, read_data, mem_alu_result,
               mem_write_reg, wb_hold, wb_flush, id_rs, id_rt,
               id_rdata1_in, id_rdata2_in,
        output MEM_WB_rd, wb_regwrite, WB_mux5_writedata,
               id_rdata1_out, id_rdata2_out, retire_count
    );
endinterface

// File: rtl/mem_wb_writeback.sv
// MIPS writeback stage: MEM/WB pipeline register, writeback data select,
// same-cycle register-file bypass to decode, and a retired-write counter.
module mem_wb_writeback #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    mem_wb_writeback_if.slave wb
);

    logic                   regwrite_q;
    logic                   memtoreg_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [DATA_WIDTH-1:0]  alures_q;
    logic [4:0]             rd_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic                   load_regwrite;
    logic [DATA_WIDTH-1:0]  writedata;
    logic                   bypass1;
    logic                   bypass2;

    // Writes to $0 are dropped at capture time so they never reach the port or the counter.
    assign load_regwrite = wb.MEM_WB_regwrite & (wb.mem_write_reg != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rdata_q    <= '0;
            alures_q   <= '0;
            rd_q       <= 5'd0;
            count_q    <= '0;
        end else if (wb.wb_flush) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rdata_q    <= '0;
            alures_q   <= '0;
            rd_q       <= 5'd0;
        end else if (!wb.wb_hold) begin
            regwrite_q <= load_regwrite;
            memtoreg_q <= wb.MEM_WB_memtoreg;
            rdata_q    <= wb.read_data;
            alures_q   <= wb.mem_alu_result;
            rd_q       <= wb.mem_write_reg;
            if (load_regwrite) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        writedata = alures_q;
        if (memtoreg_q) begin
            writedata = rdata_q;
        end
    end

    // Register file writes late in the cycle, so decode would otherwise read stale data.
    always_comb begin
        bypass1 = 1'b0;
        bypass2 = 1'b0;
        if (regwrite_q && (rd_q == wb.id_rs) && (wb.id_rs != 5'd0)) begin
            bypass1 = 1'b1;
        end
        if (regwrite_q && (rd_q == wb.id_rt) && (wb.id_rt != 5'd0)) begin
            bypass2 = 1'b1;
        end
    end

    assign wb.wb_regwrite       = regwrite_q;
    assign wb.MEM_WB_rd         = rd_q;
    assign wb.WB_mux5_writedata = writedata;
    assign wb.id_rdata1_out     = bypass1 ? writedata : wb.id_rdata1_in;
    assign wb.id_rdata2_out     = bypass2 ? writedata : wb.id_rdata2_in;
    assign wb.retire_count      = count_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Testbench for mem_wb_writeback: vector table checked through a scoreboard queue,
// plus a counter-wrap sequence on a narrow-counter instance.
module tb_mem_wb_writeback;

    typedef struct {
        logic        rst_n;
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] read_data;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        hold;
        logic        flush;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] in1;
        logic [31:0] in2;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wd;
        logic [31:0] exp_out1;
        logic [31:0] exp_out2;
        logic [31:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] out1;
        logic [31:0] out2;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst4_n;
    int   num_checks = 0;
    int   num_failures = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mem_wb_writeback_if #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) wif ();
    mem_wb_writeback_if #(.DATA_WIDTH(32), .COUNT_WIDTH(4))  wif4 ();

    mem_wb_writeback #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wif.slave)
    );

    mem_wb_writeback #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .wb    (wif4.slave)
    );

    function automatic vec_t mk(
        logic r, logic we, logic m2r, logic [31:0] rdat, logic [31:0] alu, logic [4:0] wr,
        logic hold, logic flush, logic [4:0] rs, logic [4:0] rt, logic [31:0] in1, logic [31:0] in2,
        logic e_we, logic [4:0] e_rd, logic [31:0] e_wd, logic [31:0] e_o1, logic [31:0] e_o2,
        logic [31:0] e_cnt);
        vec_t v;
        v.rst_n = r;      v.regwrite = we;   v.memtoreg = m2r;  v.read_data = rdat;
        v.alu = alu;      v.wr = wr;         v.hold = hold;     v.flush = flush;
        v.rs = rs;        v.rt = rt;         v.in1 = in1;       v.in2 = in2;
        v.exp_we = e_we;  v.exp_rd = e_rd;   v.exp_wd = e_wd;
        v.exp_out1 = e_o1; v.exp_out2 = e_o2; v.exp_cnt = e_cnt;
        return v;
    endfunction

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one vector ahead of the rising edge and queue what should appear after it.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n                = v.rst_n;
        wif.MEM_WB_regwrite  = v.regwrite;
        wif.MEM_WB_memtoreg  = v.memtoreg;
        wif.read_data        = v.read_data;
        wif.mem_alu_result   = v.alu;
        wif.mem_write_reg    = v.wr;
        wif.wb_hold          = v.hold;
        wif.wb_flush         = v.flush;
        wif.id_rs            = v.rs;
        wif.id_rt            = v.rt;
        wif.id_rdata1_in     = v.in1;
        wif.id_rdata2_in     = v.in2;
        e.we = v.exp_we; e.rd = v.exp_rd; e.wd = v.exp_wd;
        e.out1 = v.exp_out1; e.out2 = v.exp_out2; e.cnt = v.exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            num_checks++;
            num_failures++;
            $display("[TB] FAIL scoreboard_empty vec %0d: got 0 entries expected 1", idx);
        end else begin
            e = sb_q.pop_front();
            check_field($sformatf("v%0d wb_regwrite", idx), {31'b0, wif.wb_regwrite}, {31'b0, e.we});
            check_field($sformatf("v%0d MEM_WB_rd", idx), {27'b0, wif.MEM_WB_rd}, {27'b0, e.rd});
            check_field($sformatf("v%0d writedata", idx), wif.WB_mux5_writedata, e.wd);
            check_field($sformatf("v%0d id_rdata1_out", idx), wif.id_rdata1_out, e.out1);
            check_field($sformatf("v%0d id_rdata2_out", idx), wif.id_rdata2_out, e.out2);
            check_field($sformatf("v%0d retire_count", idx), wif.retire_count, e.cnt);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        wif4.MEM_WB_regwrite = 1'b0; wif4.MEM_WB_memtoreg = 1'b0;
        wif4.read_data = '0;         wif4.mem_alu_result = 32'h0000_00AA;
        wif4.mem_write_reg = 5'd1;   wif4.wb_hold = 1'b0;  wif4.wb_flush = 1'b0;
        wif4.id_rs = 5'd0;           wif4.id_rt = 5'd0;
        wif4.id_rdata1_in = '0;      wif4.id_rdata2_in = '0;

        //              rst we m2r read_data     alu           wr  hld fl rs  rt  in1           in2            we rd  wd            out1          out2          cnt
        vecs.push_back(mk(0, 1, 1, 32'h1111,     32'h2222,     3,  0, 0, 3,  4,  32'hA1,       32'hA2,        0, 0,  32'h0,        32'hA1,       32'hA2,       0));
        vecs.push_back(mk(0, 1, 1, 32'h1111,     32'h2222,     3,  0, 0, 3,  4,  32'hA1,       32'hA2,        0, 0,  32'h0,        32'hA1,       32'hA2,       0));
        vecs.push_back(mk(1, 1, 0, 32'h5555,     32'h1234,     8,  0, 0, 0,  0,  32'h10,       32'h20,        1, 8,  32'h1234,     32'h10,       32'h20,       1));
        vecs.push_back(mk(1, 1, 1, 32'hDEADBEEF, 32'h9999,     9,  0, 0, 9,  8,  32'h30,       32'h40,        1, 9,  32'hDEADBEEF, 32'hDEADBEEF, 32'h40,       2));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'hFFFFFFFF, 0,  0, 0, 0,  0,  32'h50,       32'h60,        0, 0,  32'hFFFFFFFF, 32'h50,       32'h60,       2));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'hCAFE0001, 5,  0, 0, 5,  6,  32'h0,        32'h77,        1, 5,  32'hCAFE0001, 32'hCAFE0001, 32'h77,       3));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(1, 1, 1, 32'h1000 + i, 32'h2000 + i, 5'(10 + i), 1, 0, 5, 5, 32'h1, 32'h2,
                              1, 5, 32'hCAFE0001, 32'hCAFE0001, 32'hCAFE0001, 3));
        end
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h7777,     7,  1, 1, 5,  5,  32'h3,        32'h4,         0, 0,  32'h0,        32'h3,        32'h4,        3));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hABCD,     12, 0, 0, 12, 12, 32'h5,        32'h6,         0, 12, 32'hABCD,     32'h5,        32'h6,        3));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h1,        12, 0, 0, 12, 3,  32'h5,        32'h6,         1, 12, 32'h1,        32'h1,        32'h6,        4));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h88,       13, 1, 0, 12, 12, 32'h7,        32'h8,         0, 0,  32'h0,        32'h7,        32'h8,        0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h22,       2,  0, 0, 1,  2,  32'h9,        32'hA,         1, 2,  32'h22,       32'h9,        32'h22,       1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h33,       3,  0, 1, 2,  2,  32'hB,        32'hC,         0, 0,  32'h0,        32'hB,        32'hC,        0));
        vecs.push_back(mk(1, 1, 1, 32'h44,       32'h0,        4,  0, 0, 4,  4,  32'hD,        32'hE,         1, 4,  32'h44,       32'h44,       32'h44,       1));
        vecs.push_back(mk(1, 1, 1, 32'h55,       32'h0,        6,  0, 1, 4,  6,  32'hD,        32'hE,         0, 0,  32'h0,        32'hD,        32'hE,        1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Counter wrap on the 4-bit instance: 15 writes reach all-ones, holds do not recount, the 16th wraps.
        @(negedge clk);
        @(negedge clk);
        rst4_n = 1'b1;
        wif4.MEM_WB_regwrite = 1'b1;
        repeat (15) @(negedge clk);
        check_field("wrap pre_count", {28'b0, wif4.retire_count}, 32'hF);
        wif4.wb_hold = 1'b1;
        wif4.mem_write_reg = 5'd2;
        repeat (2) @(negedge clk);
        check_field("wrap held_count", {28'b0, wif4.retire_count}, 32'hF);
        check_field("wrap held_rd", {27'b0, wif4.MEM_WB_rd}, 32'd1);
        wif4.wb_hold = 1'b0;
        @(negedge clk);
        check_field("wrap count", {28'b0, wif4.retire_count}, 32'h0);
        check_field("wrap wb_regwrite", {31'b0, wif4.wb_regwrite}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

Writeback stage of the five-stage MIPS pipeline, closing the loop opened by the memory stage. Captures memory-stage results in the MEM/WB pipeline register, selects load data or ALU result, and drives the register-file write port back into the decode stage. Also bypasses same-cycle register-file write-then-read hazards for decode, suppresses writes to `$0`, and counts retired register writes for debug.

## Interface
- `DATA_WIDTH`, 32, datapath width.
- `COUNT_WIDTH`, 32, width of the retired-write counter.

- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `MEM_WB_regwrite`  in  1  register-write control from the memory stage.
- `MEM_WB_memtoreg`  in  1  1 selects load data, 0 selects the ALU result.
- `read_data`  in  DATA_WIDTH  data-memory read data.
- `mem_alu_result`  in  DATA_WIDTH  ALU result passed through the memory stage.
- `mem_write_reg`  in  5  destination register.
- `wb_hold`  in  1  stall: keep the MEM/WB register contents.
- `wb_flush`  in  1  load a bubble into the MEM/WB register.
- `id_rs`, `id_rt`  in  5 each  decode-stage source register numbers.
- `id_rdata1_in`, `id_rdata2_in`  in  DATA_WIDTH each  raw register-file read data.
- `MEM_WB_rd`  out  5  register-file write address.
- `wb_regwrite`  out  1  register-file write enable.
- `WB_mux5_writedata`  out  DATA_WIDTH  register-file write data.
- `id_rdata1_out`, `id_rdata2_out`  out  DATA_WIDTH each  read data after bypass.
- `retire_count`  out  COUNT_WIDTH  number of committed register writes.

## Operation
- MEM/WB register fields: `regwrite`, `memtoreg`, `rdata`, `alures`, `rd`. Reset value of every field is 0.
- Priority on each rising edge: reset, then flush, then hold, then load.
  - Reset: all fields are 0 and `retire_count` is 0.
  - Flush: `regwrite`, `memtoreg` and `rd` are 0. Data fields are don't-care and are cleared to 0.
  - Hold: all fields keep their values.
  - Load: all fields capture their inputs, except that `regwrite` captures `MEM_WB_regwrite & (mem_write_reg != 0)`.
- Register-file write port:
  - `wb_regwrite` = `regwrite` field.
  - `MEM_WB_rd` = `rd` field.
  - `WB_mux5_writedata` = `memtoreg ? rdata : alures`.
- Bypass for `id_rdata1_out` (`id_rdata2_out` uses `id_rt` in the same way):
  - If `wb_regwrite` is 1, `MEM_WB_rd` equals `id_rs`, and `id_rs` is not 0, the output is `WB_mux5_writedata`.
  - Otherwise the output is `id_rdata1_in`.
- Counter:
  - `retire_count` increments by 1 on a load edge whose loaded `regwrite` is 1.
  - It does not increment on hold or flush edges.
  - It wraps from all-ones to 0.
- A held write stays presented to the register file. Rewriting the same value is idempotent and is not recounted.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the write port and bypass paths after edge N.
- Bypass and the writedata mux are combinational from register state and `id_*` inputs. No added cycle.
- All outputs are 0 during and immediately after reset.
  - `id_rdata*_out` follow `id_rdata*_in` because `wb_regwrite` = 0.
- Boundary cases:
  - Reset asserted mid-hold or mid-flush wins on that edge.
  - Hold and flush asserted together: flush wins.
  - `mem_write_reg` = 0 with `MEM_WB_regwrite` = 1: no write and no count.
  - `id_rs` = `id_rt` = `MEM_WB_rd`: both outputs are bypassed.

## Test plan
- Reset: drive `rst_n` = 0 for 2 cycles with nonzero inputs -> every output and `retire_count` is 0; `id_rdata1_out` = `id_rdata1_in`.
- ALU write then load write:
  - `alu_result` = 0x0000_1234, `rd` = 8, `memtoreg` = 0 -> next cycle `wb_regwrite` = 1, `MEM_WB_rd` = 8, writedata = 0x1234.
  - Then `read_data` = 0xDEAD_BEEF, `memtoreg` = 1, `rd` = 9 -> writedata = 0xDEADBEEF; `retire_count` = 2.
- `$0` suppression: `regwrite` = 1, `rd` = 0, `alu_result` = 0xFFFF_FFFF -> `wb_regwrite` = 0, count unchanged, no bypass even when `id_rs` = 0.
- Bypass: pending write to `rd` = 5 of 0xCAFE_0001, `id_rs` = 5, `id_rt` = 6, `id_rdata1_in` = 0x0, `id_rdata2_in` = 0x77 -> `id_rdata1_out` = 0xCAFE0001, `id_rdata2_out` = 0x77.
- Hold and flush:
  - Hold for 3 cycles with changing inputs -> outputs frozen, count +0.
  - Hold and flush together -> `wb_regwrite` = 0, `MEM_WB_rd` = 0.
- Counter wrap: force `retire_count` to 0xFFFF_FFFF, then one valid write -> 0x0000_0000.
